// File: rtl/dbus_rr_arbiter4.sv
// dbus_rr_arbiter4: four-master round-robin arbiter onto one data-bus slave.
// Define DBUS_ARB_TIMEOUT_EN to add a 255-cycle BUSY watchdog driving toErr.
module dbus_rr_arbiter4 (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] addrM,
  input  logic [127:0] doutM,
  input  logic [3:0]   stbM,
  input  logic [3:0]   weM,
  input  logic [15:0]  dmM,
  output logic [31:0]  dinM,
  output logic [3:0]   nakM,
  output logic [31:0]  addrS,
  output logic [31:0]  dinS,
  output logic         stbS,
  output logic         weS,
  output logic [3:0]   dmS,
  input  logic [31:0]  doutS,
  input  logic         nakS,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         toErr
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;
  logic [1:0] r_owner, r_last, w_pick;
  logic w_to, w_own_stb;
  logic [3:0] w_own_oh;
  assign w_own_stb = stbM[r_owner];
  assign w_own_oh = 4'b0001 << r_owner;
`ifdef DBUS_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_to_err;
  assign w_to = r_state == BUSY && w_own_stb && nakS && r_cnt == 8'hff;
  assign toErr = r_to_err;
  // held at zero while idle so every BUSY tenure starts from a fresh count
  always_ff @(posedge clk)
    if (rst) begin
      r_cnt <= 8'd0;
      r_to_err <= 1'b0;
    end else begin
      r_cnt <= r_state == IDLE ? 8'd0 : r_cnt + 8'd1;
      if (w_to) r_to_err <= 1'b1;
    end
`else
  assign w_to = 1'b0;
  assign toErr = 1'b0;
`endif
  // nearest requester after the last one served wins
  always_comb begin
    w_pick = r_last + 2'd1;
    for (int i = 3; i >= 0; i--)
      if (stbM[r_last + 2'(i + 1)]) w_pick = r_last + 2'(i + 1);
  end
  assign busy = r_state == BUSY;
  assign grant = r_owner;
  assign addrS = addrM[{r_owner, 5'd0} +: 32];
  assign dinS = doutM[{r_owner, 5'd0} +: 32];
  assign dmS = dmM[{r_owner, 2'd0} +: 4];
  assign weS = weM[r_owner];
  assign stbS = busy && w_own_stb && !w_to;
  assign dinM = w_to ? 32'hDEADBEEF : doutS;
  assign nakM = busy ? stbM & (~w_own_oh | {4{nakS && !w_to}}) : stbM;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_last <= 2'd3;
    end else if (r_state == IDLE) begin
      if (|stbM) begin
        r_state <= BUSY;
        r_owner <= w_pick;
      end
    end else if (!w_own_stb) r_state <= IDLE;
    else if (!nakS || w_to) begin
      r_state <= IDLE;
      r_last <= r_owner;
    end
endmodule
